// File: rtl/cmp_share_arbiter_pkg.sv
// Shared types and helpers for the shared-comparator arbiter.
package cmp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 4;

  typedef struct packed {
    logic lesser;
    logic greater;
    logic equal;
  } cmp_result_t;

  // Requester ID width; at least one bit so a two-requester build still has an ID.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between compare clients and the shared comparator.
interface cmp_share_arbiter_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
);
  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_lesser;
  logic                  rsp_greater;
  logic                  rsp_equal;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lesser, rsp_greater, rsp_equal
  );

  // Client / consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lesser, rsp_greater, rsp_equal
  );

endinterface

// File: rtl/cmp_share_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan ptr, ptr+1, ... mod NREQ and take the first active request.
  always_comb begin : scan
    logic [IDW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mag_cmp.sv
// Combinational unsigned magnitude comparator datapath.
module mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_result_t      res
);

  // Exactly one flag is set for any operand pair.
  always_comb begin
    res         = '0;
    res.lesser  = (a < b);
    res.greater = (a > b);
    res.equal   = (a == b);
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one magnitude comparator among NREQ requesters,
// with a single registered result stage under consumer backpressure.
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input logic                clk,
  input logic                rst_n,
  cmp_share_arbiter_if.slave bus
);

  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  cmp_result_t      cmp_res;
  cmp_result_t      rsp_res;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic             can_accept;
  logic             xfer;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Route the granted requester's operands into the shared comparator.
  always_comb begin
    op_a = bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
    op_b = bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
  end

  mag_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_res)
  );

  // Ready is held low during reset so no grant is visible while rst_n is asserted.
  assign can_accept    = ~rsp_valid | bus.rsp_ready;
  assign xfer          = pick_any & can_accept & rst_n;
  assign bus.req_ready = grant & {NREQ{can_accept & rst_n}};

  // Priority moves to the slot after the winner; wrap explicitly for non-power-of-two NREQ.
  always_comb begin
    ptr_next = pick_idx + IDW'(1);
    if (int'(pick_idx) == NREQ - 1) begin
      ptr_next = '0;
    end
  end

  // Priority pointer only advances on an actual transfer, never on a stalled grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_next;
    end
  end

  // Result register: load on transfer, drop valid on drain, hold flags/ID otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= pick_idx;
      rsp_res   <= cmp_res;
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = rsp_id;
  assign bus.rsp_lesser  = rsp_res.lesser;
  assign bus.rsp_greater = rsp_res.greater;
  assign bus.rsp_equal   = rsp_res.equal;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed vector bench for cmp_share_arbiter (WIDTH=32, NREQ=4).
module tb_cmp_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int NVEC  = 24;

  // Result flag encoding used in the table: {lesser, greater, equal}.
  localparam logic [2:0] FL = 3'b100;
  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] FE = 3'b001;

  // Round-robin operand set: id0 lesser, id1 equal, id2 greater, id3 greater.
  localparam logic [127:0] RA = {32'd3, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] RB = {32'd2, 32'd2, 32'd2, 32'd2};

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] a;
    logic [127:0] b;
    logic         rsp_ready;
    logic [3:0]   exp_ready;
    logic         exp_valid;
    logic [1:0]   exp_id;
    logic [2:0]   exp_flags;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  vec_t vecs[NVEC];

  cmp_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] v, input logic [127:0] a,
                              input logic [127:0] b, input logic rr,
                              input logic [3:0] er, input logic ev,
                              input logic [1:0] eid, input logic [2:0] ef);
    vec_t r;
    r.valid = v; r.a = a; r.b = b; r.rsp_ready = rr;
    r.exp_ready = er; r.exp_valid = ev; r.exp_id = eid; r.exp_flags = ef;
    return r;
  endfunction

  function automatic logic [127:0] lane(input int i, input logic [31:0] x);
    logic [127:0] r;
    r = '0;
    r[i*32 +: 32] = x;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] rsp_tuple();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_greater, bus.rsp_equal};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [127:0] a,
                       input logic [127:0] b, input logic rr);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rr;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // single requester 2: lesser, greater, equal, then drain
    vecs[0]  = mk(4'b0100, lane(2, 32'd22),   lane(2, 32'd444),  1'b1, 4'b0100, 1'b1, 2'd2, FL);
    vecs[1]  = mk(4'b0100, lane(2, 32'd777),  lane(2, 32'd111),  1'b1, 4'b0100, 1'b1, 2'd2, FG);
    vecs[2]  = mk(4'b0100, lane(2, 32'd8888), lane(2, 32'd8888), 1'b1, 4'b0100, 1'b1, 2'd2, FE);
    vecs[3]  = mk(4'b0000, '0, '0, 1'b1, 4'b0000, 1'b0, 2'd2, FE);
    // unsigned extremes on requester 0 (ptr=3 wraps to 0)
    vecs[4]  = mk(4'b0001, lane(0, 32'hFFFF_FFFF), '0, 1'b1, 4'b0001, 1'b1, 2'd0, FG);
    vecs[5]  = mk(4'b0001, '0, lane(0, 32'h8000_0000), 1'b1, 4'b0001, 1'b1, 2'd0, FL);
    // all four valid: rotation from ptr=1, one result per cycle
    vecs[6]  = mk(4'b1111, RA, RB, 1'b1, 4'b0010, 1'b1, 2'd1, FE);
    vecs[7]  = mk(4'b1111, RA, RB, 1'b1, 4'b0100, 1'b1, 2'd2, FG);
    vecs[8]  = mk(4'b1111, RA, RB, 1'b1, 4'b1000, 1'b1, 2'd3, FG);
    vecs[9]  = mk(4'b1111, RA, RB, 1'b1, 4'b0001, 1'b1, 2'd0, FL);
    vecs[10] = mk(4'b1111, RA, RB, 1'b1, 4'b0010, 1'b1, 2'd1, FE);
    // backpressure three cycles on (id1, 2 vs 2): held, no ready, ptr frozen at 2
    vecs[11] = mk(4'b1111, RA, RB, 1'b0, 4'b0000, 1'b1, 2'd1, FE);
    vecs[12] = mk(4'b1111, RA, RB, 1'b0, 4'b0000, 1'b1, 2'd1, FE);
    vecs[13] = mk(4'b1111, RA, RB, 1'b0, 4'b0000, 1'b1, 2'd1, FE);
    // release: drain and new transfer in the same cycle, grant 2 proves ptr held
    vecs[14] = mk(4'b1111, RA, RB, 1'b1, 4'b0100, 1'b1, 2'd2, FG);
    vecs[15] = mk(4'b1011, RA, RB, 1'b1, 4'b1000, 1'b1, 2'd3, FG);
    vecs[16] = mk(4'b0011, RA, RB, 1'b1, 4'b0001, 1'b1, 2'd0, FL);
    vecs[17] = mk(4'b0010, RA, RB, 1'b1, 4'b0010, 1'b1, 2'd1, FE);
    vecs[18] = mk(4'b0000, RA, RB, 1'b1, 4'b0000, 1'b0, 2'd1, FE);
    // skip idle: only 3 and 1 valid with ptr=2 -> 3, 1, 3, 1
    vecs[19] = mk(4'b1010, RA, RB, 1'b1, 4'b1000, 1'b1, 2'd3, FG);
    vecs[20] = mk(4'b1010, RA, RB, 1'b1, 4'b0010, 1'b1, 2'd1, FE);
    vecs[21] = mk(4'b1010, RA, RB, 1'b1, 4'b1000, 1'b1, 2'd3, FG);
    vecs[22] = mk(4'b0010, RA, RB, 1'b1, 4'b0010, 1'b1, 2'd1, FE);
    vecs[23] = mk(4'b0000, RA, RB, 1'b1, 4'b0000, 1'b0, 2'd1, FE);

    // reset state, with requests present to show ready is gated
    rst_n = 1'b0;
    drive(4'b1111, RA, RB, 1'b1);
    #3;
    check("reset_rsp", 32'(rsp_tuple()), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    drive(4'b0000, '0, '0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rsp_ready);
      #1;
      check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp", i), 32'(rsp_tuple()),
            32'({vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_flags}));
    end

    // mid-stream reset with a held result; requester 0 moves ptr to 1 first
    @(negedge clk);
    drive(4'b0001, lane(0, 32'd5), lane(0, 32'd9), 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_rsp", 32'(rsp_tuple()), 32'({1'b1, 2'd0, FL}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rsp", 32'(rsp_tuple()), 32'd0);
    check("async_reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0101, lane(0, 32'd7) | lane(2, 32'd4), lane(0, 32'd7) | lane(2, 32'd1), 1'b1);
    #1;
    check("post_reset_rsp_idle", 32'(rsp_tuple()), 32'd0);
    check("post_reset_ready_lowest", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_reset_rsp0", 32'(rsp_tuple()), 32'({1'b1, 2'd0, FE}));
    @(negedge clk);
    drive(4'b0100, lane(2, 32'd4), lane(2, 32'd1), 1'b1);
    #1;
    check("post_reset_ready2", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    check("post_reset_rsp2", 32'(rsp_tuple()), 32'({1'b1, 2'd2, FG}));
    @(negedge clk);
    drive(4'b0000, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    check("final_drain", 32'(rsp_tuple()), 32'({1'b0, 2'd2, FG}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
